// File: rtl/vga_board_renderer.sv
// Three-stage p_tick-enabled pixel pipeline: board cell lookup, glyph fetch, cursor overlay.
// Sync signals are delayed through a matching 3-deep shift register so rgb/hsync/vsync stay aligned.
module vga_board_renderer #(
   parameter int          TILE_LOG2 = 4,
   parameter int          COLS      = 16,
   parameter int          ROWS      = 16,
   parameter int          ORG_X     = 192,
   parameter int          ORG_Y     = 112,
   parameter logic [11:0] BG_RGB    = 12'h222,
   parameter logic [11:0] CUR_RGB   = 12'hF00,
   parameter int          BLINK_BIT = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p_tick,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        video_on,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [3:0]  cursor_x,
   input  logic [3:0]  cursor_y,
   output logic [7:0]  cell_addr,
   input  logic [3:0]  cell_data,
   output logic [11:0] glyph_addr,
   input  logic [11:0] glyph_data,
   output logic [11:0] rgb,
   output logic        hsync,
   output logic        vsync
);

   localparam int                   TILE   = 1 << TILE_LOG2;
   localparam logic [10:0]          X_LO   = 11'(ORG_X);
   localparam logic [10:0]          X_HI   = 11'(ORG_X + COLS * TILE);
   localparam logic [10:0]          Y_LO   = 11'(ORG_Y);
   localparam logic [10:0]          Y_HI   = 11'(ORG_Y + ROWS * TILE);
   localparam logic [7:0]           COLS8  = 8'(COLS);
   localparam logic [TILE_LOG2-1:0] T_LAST = '1;

   logic [10:0]          x_ext, y_ext, dx, dy;
   logic [7:0]           col, row;
   logic [TILE_LOG2-1:0] tx, ty;
   logic                 in_board, on_edge, cur_hit;
   logic [3:0]           code_fix;

   logic [2:0]           hs_d, vs_d;
   logic [7:0]           frame_cnt;
   logic [3:0]           cur_x_l, cur_y_l;
   logic                 cur_vld;

   logic                 s1_von, s1_inb, s1_cur;
   logic [TILE_LOG2-1:0] s1_tx, s1_ty;
   logic                 s2_von, s2_inb, s2_cur;

   // 11-bit compare/subtract so pixels left of or above the board cannot wrap into it
   assign x_ext    = {1'b0, pixel_x};
   assign y_ext    = {1'b0, pixel_y};
   assign dx       = x_ext - X_LO;
   assign dy       = y_ext - Y_LO;
   assign col      = 8'(dx >> TILE_LOG2);
   assign row      = 8'(dy >> TILE_LOG2);
   assign tx       = dx[TILE_LOG2-1:0];
   assign ty       = dy[TILE_LOG2-1:0];
   assign in_board = video_on && (x_ext >= X_LO) && (x_ext < X_HI) &&
                     (y_ext >= Y_LO) && (y_ext < Y_HI);
   assign on_edge  = (tx == '0) || (tx == T_LAST) || (ty == '0) || (ty == T_LAST);
   // No cursor is drawn until one has been sampled at a frame start
   assign cur_hit  = cur_vld && (col == 8'(cur_x_l)) && (row == 8'(cur_y_l)) &&
                     on_edge && !frame_cnt[BLINK_BIT];
   assign code_fix = (cell_data >= 4'd12) ? 4'd10 : cell_data;

   assign hsync = hs_d[2];
   assign vsync = vs_d[2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hs_d       <= 3'b111;
         vs_d       <= 3'b111;
         frame_cnt  <= 8'd0;
         cur_x_l    <= 4'd0;
         cur_y_l    <= 4'd0;
         cur_vld    <= 1'b0;
         s1_von     <= 1'b0;
         s1_inb     <= 1'b0;
         s1_cur     <= 1'b0;
         s1_tx      <= '0;
         s1_ty      <= '0;
         s2_von     <= 1'b0;
         s2_inb     <= 1'b0;
         s2_cur     <= 1'b0;
         cell_addr  <= 8'd0;
         glyph_addr <= 12'd0;
         rgb        <= 12'd0;
      end else if (p_tick) begin
         hs_d <= {hs_d[1:0], hsync_in};
         vs_d <= {vs_d[1:0], vsync_in};
         if (vs_d[0] && !vsync_in) begin
            frame_cnt <= frame_cnt + 8'd1;
            cur_x_l   <= cursor_x;
            cur_y_l   <= cursor_y;
            cur_vld   <= 1'b1;
         end

         s1_von    <= video_on;
         s1_inb    <= in_board;
         s1_cur    <= cur_hit;
         s1_tx     <= tx;
         s1_ty     <= ty;
         cell_addr <= 8'(row * COLS8 + col);

         s2_von     <= s1_von;
         s2_inb     <= s1_inb;
         s2_cur     <= s1_cur;
         glyph_addr <= {code_fix, s1_ty, s1_tx};

         if (!s2_von)
            rgb <= 12'd0;
         else if (!s2_inb)
            rgb <= BG_RGB;
         else if (s2_cur)
            rgb <= CUR_RGB;
         else
            rgb <= glyph_data;
      end
   end

endmodule
